dcm_reset_sequencer: RTL



---
 rtl/clockman_pkg.sv | 23 ++
 rtl/dcm_reset_sequencer_if.sv | 24 ++
 rtl/sync2.sv | 21 ++
 rtl/dcm_reset_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/clockman_pkg.sv
// Shared constants for the DCM clock-management blocks: state encoding, STATUS bit
// indices and a counter-width helper.
package clockman_pkg;

   localparam logic [2:0] RESET_HOLD = 3'd0;
   localparam logic [2:0] WAIT_LOCK  = 3'd1;
   localparam logic [2:0] SETTLE     = 3'd2;
   localparam logic [2:0] RUN        = 3'd3;
   localparam logic [2:0] FAIL       = 3'd4;

   localparam int unsigned DCM_STAT_CLKIN_STOPPED = 1;

   // Width able to count 0 .. max(a,b,c)-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/dcm_reset_sequencer_if.sv
// DCM sequencer signal bundle: master is the sequencer, slave is the DCM/core side.
interface dcm_reset_sequencer_if;

   logic       dcm_locked;
   logic [7:0] dcm_status;
   logic       restart_req;
   logic       dcm_rst;
   logic       core_rst_n;
   logic       running;
   logic       fail;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   modport master (
      input  dcm_locked, dcm_status, restart_req,
      output dcm_rst, core_rst_n, running, fail, lock_lost, retry_cnt
   );

   modport slave (
      output dcm_locked, dcm_status, restart_req,
      input  dcm_rst, core_rst_n, running, fail, lock_lost, retry_cnt
   );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/dcm_reset_sequencer.sv
// DCM reset/lock sequencer on the reference clock: pulses DCM RST, qualifies lock, releases
// core reset, retries on timeout. Define DCM_STATUS_MON_EN to also re-sequence on CLKIN stop.
module dcm_reset_sequencer
   import clockman_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT  = 65536,
   parameter int unsigned SETTLE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dcm_reset_sequencer_if.master bus_io
);

   localparam int unsigned CntW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
   localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRIES);

   logic            locked_s;
   logic            stopped_s;
   logic            unused_status;
   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      retry_q, retry_d;
   logic            lock_lost_q, lock_lost_d;
   logic            dcm_rst_q, core_rst_n_q, running_q, fail_q;

   sync2 u_sync_lock (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus_io.dcm_locked),
      .q_o   (locked_s)
   );

`ifdef DCM_STATUS_MON_EN
   sync2 u_sync_stat (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus_io.dcm_status[DCM_STAT_CLKIN_STOPPED]),
      .q_o   (stopped_s)
   );
`else
   assign stopped_s = 1'b0;
`endif

   assign unused_status = ^bus_io.dcm_status;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      retry_d     = retry_q;
      lock_lost_d = lock_lost_q;
      if (bus_io.restart_req) begin
         state_d     = RESET_HOLD;
         retry_d     = 4'd0;
         lock_lost_d = 1'b0;
      end else begin
         case (state_q)
            RESET_HOLD: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == RstLast) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               cnt_d = cnt_q + 1'b1;
               if (stopped_s) begin
                  state_d = RESET_HOLD;
               end else if (locked_s) begin
                  state_d = SETTLE;
               end else if (cnt_q == TimeoutLast) begin
                  if (retry_q == MaxRetry) begin
                     state_d = FAIL;
                  end else begin
                     retry_d = retry_q + 4'd1;
                     state_d = RESET_HOLD;
                  end
               end
            end
            SETTLE: begin
               cnt_d = cnt_q + 1'b1;
               if (stopped_s)             state_d = RESET_HOLD;
               else if (!locked_s)        state_d = WAIT_LOCK;
               else if (cnt_q == SettleLast) state_d = RUN;
            end
            RUN: begin
               if (!locked_s || stopped_s) begin
                  lock_lost_d = 1'b1;
                  retry_d     = 4'd0;
                  state_d     = RESET_HOLD;
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RESET_HOLD;
         endcase
      end
      // Restart also re-arms the counter when already in RESET_HOLD.
      if (state_d != state_q || bus_io.restart_req) cnt_d = '0;
   end

   // Outputs are registered from state_d so they change on the same edge as state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RESET_HOLD;
         cnt_q        <= '0;
         retry_q      <= 4'd0;
         lock_lost_q  <= 1'b0;
         dcm_rst_q    <= 1'b1;
         core_rst_n_q <= 1'b0;
         running_q    <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         lock_lost_q  <= lock_lost_d;
         dcm_rst_q    <= (state_d == RESET_HOLD);
         core_rst_n_q <= (state_d == RUN);
         running_q    <= (state_d == RUN);
         fail_q       <= (state_d == FAIL);
      end
   end

   assign bus_io.dcm_rst    = dcm_rst_q;
   assign bus_io.core_rst_n = core_rst_n_q;
   assign bus_io.running    = running_q;
   assign bus_io.fail       = fail_q;
   assign bus_io.lock_lost  = lock_lost_q;
   assign bus_io.retry_cnt  = retry_q;

endmodule
